// File: rtl/i2c_result_target.sv
// rtl/i2c_result_target.sv - oversampled I2C target capturing a 4-byte result write
// Optional readback of the stored result on I2C reads: define I2C_RESULT_READBACK_EN.
`timescale 1ns/1ps
module i2c_result_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h0D,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i2c_scl,
   inout  wire         i2c_sda,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy,
   output logic        addr_hit
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ADDR     = 3'd1;
   localparam logic [2:0] ADDR_ACK = 3'd2;
   localparam logic [2:0] WR_DATA  = 3'd3;
   localparam logic [2:0] WR_ACK   = 3'd4;
   localparam logic [2:0] IGNORE   = 3'd7;
`ifdef I2C_RESULT_READBACK_EN
   localparam logic [2:0] RD_DATA  = 3'd5;
   localparam logic [2:0] RD_ACK   = 3'd6;
   localparam bit         READ_OK  = 1'b1;
`else
   localparam bit         READ_OK  = 1'b0;
`endif

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic       scl_q, sda_q;
   logic [2:0] state, bit_cnt, byte_idx;
   logic [6:0] shreg;
   logic [31:0] shadow;
   logic       sda_oe, phase, wr_mode;

   wire scl_s = scl_sync[SYNC_STAGES-1];
   wire sda_s = sda_sync[SYNC_STAGES-1];
   wire scl_rise  = scl_s & ~scl_q;
   wire scl_fall  = ~scl_s & scl_q;
   wire start_det = scl_s & scl_q & sda_q & ~sda_s;
   wire stop_det  = scl_s & scl_q & ~sda_q & sda_s;
   wire [7:0] byte_in = {shreg, sda_s};

   // Reset gates the drive combinationally so the bus is freed in the reset cycle itself.
   assign i2c_sda = (sda_oe && reset) ? 1'b0 : 1'bz;

`ifdef I2C_RESULT_READBACK_EN
   logic [7:0] rd_byte;
   always_comb begin
      rd_byte = result[31:24];
      case (byte_idx[1:0])
         2'd1:    rd_byte = result[23:16];
         2'd2:    rd_byte = result[15:8];
         2'd3:    rd_byte = result[7:0];
         default: rd_byte = result[31:24];
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         scl_sync     <= '1;
         sda_sync     <= '1;
         scl_q        <= 1'b1;
         sda_q        <= 1'b1;
         state        <= IDLE;
         bit_cnt      <= 3'd0;
         byte_idx     <= 3'd0;
         shreg        <= 7'd0;
         shadow       <= 32'd0;
         sda_oe       <= 1'b0;
         phase        <= 1'b0;
         wr_mode      <= 1'b0;
         result       <= 32'd0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         addr_hit     <= 1'b0;
      end else begin
         scl_sync     <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
         sda_sync     <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
         scl_q        <= scl_s;
         sda_q        <= sda_s;
         result_valid <= 1'b0;
         addr_hit     <= 1'b0;
         if (start_det || stop_det) begin
            if (stop_det && wr_mode && byte_idx == 3'd4) begin
               result       <= shadow;
               result_valid <= 1'b1;
            end
            state    <= start_det ? ADDR : IDLE;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            sda_oe   <= 1'b0;
            phase    <= 1'b0;
            wr_mode  <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shreg   <= byte_in[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (byte_in[7:1] == TARGET_ADDR && (!byte_in[0] || READ_OK)) begin
                        state    <= ADDR_ACK;
                        addr_hit <= 1'b1;
                        busy     <= 1'b1;
                        wr_mode  <= ~byte_in[0];
                        phase    <= 1'b0;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               // ACK states: first fall after the 8th bit starts the drive, the fall ending the 9th clock ends it.
               ADDR_ACK: if (scl_rise) begin
                  phase <= 1'b1;
               end else if (scl_fall) begin
                  if (!phase) begin
                     sda_oe <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     bit_cnt <= 3'd0;
                     sda_oe  <= 1'b0;
                     state   <= WR_DATA;
`ifdef I2C_RESULT_READBACK_EN
                     if (!wr_mode) begin
                        sda_oe <= ~rd_byte[7];
                        state  <= RD_DATA;
                     end
`endif
                  end
               end
               WR_DATA: if (scl_rise) begin
                  shreg   <= byte_in[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (!byte_idx[2]) begin
                        case (byte_idx[1:0])
                           2'd0:    shadow[31:24] <= byte_in;
                           2'd1:    shadow[23:16] <= byte_in;
                           2'd2:    shadow[15:8]  <= byte_in;
                           default: shadow[7:0]   <= byte_in;
                        endcase
                        state <= WR_ACK;
                        phase <= 1'b0;
                     end else begin
                        state <= IGNORE;
                        busy  <= 1'b0;
                     end
                  end
               end
               WR_ACK: if (scl_rise) begin
                  phase <= 1'b1;
               end else if (scl_fall) begin
                  if (!phase) begin
                     sda_oe <= 1'b1;
                  end else begin
                     sda_oe   <= 1'b0;
                     phase    <= 1'b0;
                     byte_idx <= byte_idx + 3'd1;
                     state    <= WR_DATA;
                  end
               end
`ifdef I2C_RESULT_READBACK_EN
               RD_DATA: if (scl_rise) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= RD_ACK;
                     phase <= 1'b0;
                  end
               end else if (scl_fall) begin
                  sda_oe <= ~rd_byte[3'd7 - bit_cnt];
               end
               // byte_idx advances at the master's ACK sample so rd_byte already holds the next byte at the fall.
               RD_ACK: if (scl_rise) begin
                  phase    <= 1'b1;
                  wr_mode  <= 1'b0;
                  byte_idx <= byte_idx + 3'd1;
                  if (sda_s) busy <= 1'b0;
               end else if (scl_fall) begin
                  if (!phase) begin
                     sda_oe <= 1'b0;
                  end else if (busy) begin
                     sda_oe  <= ~rd_byte[7];
                     bit_cnt <= 3'd0;
                     state   <= RD_DATA;
                  end else begin
                     sda_oe <= 1'b0;
                     state  <= IGNORE;
                  end
               end
`endif
               default: sda_oe <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_result_target.sv
// tb/tb_i2c_result_target.sv - directed bench driving an I2C master against i2c_result_target
`timescale 1ns/1ps
module tb_i2c_result_target;

   localparam int Q = 100;
   localparam int H = 200;

   logic        clk = 1'b0;
   logic        reset, scl, m_oe;
   wire         sda;
   logic [31:0] result;
   logic        result_valid, busy, addr_hit;

   int n_cmp = 0, n_mis = 0;
   int n_valid = 0, n_hit = 0, n_busy = 0;
   int acks;
   logic busy_at_addr, a;
   logic [7:0] rb;
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   assign sda = m_oe ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_result_target dut (
      .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
      .result(result), .result_valid(result_valid), .busy(busy), .addr_hit(addr_hit)
   );

   always @(negedge clk) begin
      if (result_valid) n_valid++;
      if (addr_hit)     n_hit++;
      if (busy)         n_busy++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      n_valid = 0; n_hit = 0; n_busy = 0;
   endtask

   task automatic send_bit(input logic b);
      m_oe = ~b; #Q; scl = 1'b1; #H; scl = 1'b0; #Q;
   endtask

   task automatic recv_bit(output logic b);
      m_oe = 1'b0; #Q; scl = 1'b1; #(H/2); b = sda; #(H/2); scl = 1'b0; #Q;
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] v);
      logic bv;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(bv);
         v[i] = bv;
      end
      send_bit(nack);
   endtask

   task automatic i2c_start();
      m_oe = 1'b0; #Q; scl = 1'b1; #Q; m_oe = 1'b1; #Q; scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_oe = 1'b1; #Q; scl = 1'b1; #Q; m_oe = 1'b0; #Q;
      #1000;
   endtask

   task automatic write_txn(input logic [7:0] ab, input logic [39:0] d, input int n, output int na);
      logic ak;
      na = 0;
      i2c_start();
      send_byte(ab, ak);
      if (!ak) na++;
      busy_at_addr = busy;
      for (int k = 0; k < n; k++) begin
         send_byte(d[39 - 8*k -: 8], ak);
         if (!ak) na++;
      end
      i2c_stop();
   endtask

   initial begin
      reset = 1'b0; scl = 1'b1; m_oe = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", result, 32'h0);
      check("rst_valid", {31'd0, result_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
      check("rst_sda", {31'd0, sda}, 32'd1);
      @(negedge clk); reset = 1'b1;
      #500;

      clear_mon();
      write_txn(8'h1A, 40'h41000000_00, 4, acks);
      check("w1_acks", acks, 5);
      check("w1_busy_mid", {31'd0, busy_at_addr}, 32'd1);
      check("w1_hit", n_hit, 1);
      check("w1_valid_pulses", n_valid, 1);
      check("w1_result", result, 32'h41000000);
      check("w1_busy_end", {31'd0, busy}, 32'd0);

      clear_mon();
      write_txn(8'h1C, 40'h40000000_00, 4, acks);
      check("w2_acks", acks, 0);
      check("w2_hit", n_hit, 0);
      check("w2_busy", n_busy, 0);
      check("w2_valid", n_valid, 0);
      check("w2_result", result, 32'h41000000);

      clear_mon();
      write_txn(8'h1A, 40'h40A000_0000, 3, acks);
      check("w3_acks", acks, 4);
      check("w3_valid", n_valid, 0);
      check("w3_result", result, 32'h41000000);

      clear_mon();
      write_txn(8'h1A, 40'h40800000_11, 5, acks);
      check("w4_acks", acks, 5);
      check("w4_valid", n_valid, 1);
      check("w4_result", result, 32'h40800000);
      check("w4_busy_end", {31'd0, busy}, 32'd0);

      clear_mon();
      i2c_start();
      send_byte(8'h1B, a);
`ifdef I2C_RESULT_READBACK_EN
      check("rd_addr_ack", {31'd0, a}, 32'd0);
      check("rd_hit", n_hit, 1);
      exp_rd = 32'h40800000;
      for (int k = 0; k < 4; k++) begin
         read_byte(k == 3, rb);
         check($sformatf("rd_byte%0d", k), {24'd0, rb}, {24'd0, exp_rd[31 - 8*k -: 8]});
      end
`else
      check("rd_addr_nack", {31'd0, a}, 32'd1);
      check("rd_hit", n_hit, 0);
      check("rd_busy", n_busy, 0);
`endif
      i2c_stop();
      check("rd_valid", n_valid, 0);
      check("rd_result", result, 32'h40800000);

      clear_mon();
      i2c_start();
      send_byte(8'h1A, a);
      send_byte(8'h12, a);
      for (int i = 7; i >= 0; i--) send_bit(1'b0);
      m_oe = 1'b0;
      #Q;
      check("mid_ack_driven", {31'd0, sda}, 32'd0);
      @(negedge clk); reset = 1'b0;
      #1;
      check("rst_sda_release", {31'd0, sda}, 32'd1);
      @(posedge clk); #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_result", result, 32'h0);
      @(negedge clk); reset = 1'b1;
      scl = 1'b1; #H; scl = 1'b0; #Q;

      clear_mon();
      write_txn(8'h1A, 40'h3F800000_00, 4, acks);
      check("w5_acks", acks, 5);
      check("w5_valid", n_valid, 1);
      check("w5_result", result, 32'h3F800000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/i2c_result_target.md
Name: i2c_result_target

Overview:
- I2C target (slave) that receives the 32-bit IEEE-754 result written by the `state_machine` I2C master.
- Sits on the `i2c_sda`/`i2c_scl` bus opposite the master.
- Oversamples SCL/SDA on the system clock, so no SCL-clocked logic.
- Assembles a 4-byte write into `result`, flags completion at STOP, and optionally serves the stored result back on I2C reads.

Parameters:
- TARGET_ADDR, 7'h0D, 7-bit I2C address this block answers to.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- i2c_scl  input  1  I2C clock from master.
- i2c_sda  inout  1  I2C data; open-drain. Drives 1'b0 or 1'bz only, never 1.
- result  output  32  last complete 4-byte write, first byte received in [31:24].
- result_valid  output  1  one-cycle pulse when `result` updates.
- busy  output  1  high from an address-matched START until STOP or NACK.
- addr_hit  output  1  one-cycle pulse when the address byte matches and ACK is driven.

Behaviour:
- Reset values (reset==0 at a clk edge):
  - `result` = 0, `result_valid` = 0, `busy` = 0, `addr_hit` = 0.
  - SDA released (z); state = IDLE; bit and byte counters = 0.
- Input synchronization and edge detection:
  - SCL/SDA pass through SYNC_STAGES flops; edges come from comparing against the previous synchronized sample.
  - START: SDA 1->0 while SCL high. STOP: SDA 0->1 while SCL high.
  - Both are detected in any state and take priority over bit processing in the same cycle.
- Bit timing:
  - Data sampled on SCL rising edge.
  - SDA drive (ACK or read data) changes only on SCL falling edge.
  - Drive is held through the following SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits MSB-first. After 8th bit:
    - Address match -> ADDR_ACK; `addr_hit` pulses; `busy` = 1.
    - Mismatch -> IGNORE with SDA released (NACK).
  - ADDR_ACK: drive SDA low for the 9th clock. Then R/W=0 -> WR_DATA; R/W=1 -> RD_DATA (see optional feature).
  - WR_DATA: shift 8 bits into the shadow register at byte index 0..3.
    - After the 8th bit -> WR_ACK, ACK if byte index < 4.
    - A 5th or later byte is NACKed and discarded -> IGNORE.
  - WR_ACK -> WR_DATA; byte index increments.
  - RD_DATA: drive byte (index 0..3, wrapping) MSB-first -> RD_ACK.
  - RD_ACK: sample master's bit. ACK (0) -> RD_DATA with next byte; NACK (1) -> IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- STOP handling:
  - If exactly 4 write bytes were ACKed since the last START: `result` <= shadow and `result_valid` = 1 for one cycle, 1 cycle after STOP detect.
  - Otherwise `result` is unchanged and there is no pulse.
  - Then -> IDLE; `busy` = 0; counters cleared.
- Repeated START (START while not IDLE): abandon the partial transfer, no `result` update, counters cleared -> ADDR.
- Reset mid-transfer: immediate return to reset values; SDA released within the same cycle that reset is sampled.
- Latency: ACK drive visible on SDA ≤ SYNC_STAGES+2 clk after SCL falling edge. The master's SCL low phase must exceed this.

Optional Feature:
- Macro I2C_RESULT_READBACK_EN.
- Defined: R/W=1 with matching address is ACKed and served from `result` (not the shadow register), bytes [31:24] first, wrapping after 4 bytes.
- Undefined: a read with matching address is NACKed (no ADDR_ACK drive) -> IGNORE; `addr_hit` does not pulse; RD_DATA/RD_ACK logic is absent.

Test Plan:
- Write to 0x1A (addr 0x0D, W), bytes 41 00 00 00, STOP -> 5 ACKs; `result` = 32'h41000000; `result_valid` one pulse; `busy` falls after STOP.
- Write to 0x1C (addr 0x0E) with bytes 40 00 00 00 -> SDA never pulled low; `addr_hit`, `busy`, `result_valid` stay 0; `result` unchanged.
- Write 0x1A, bytes 40 A0 00, STOP -> 4 ACKs, no `result_valid`; `result` holds prior 32'h41000000.
- Write 0x1A, bytes 40 80 00 00 11, STOP -> 5th byte NACKed; `result` = 32'h40800000; one pulse.
- With I2C_RESULT_READBACK_EN: 0x1B read of 4 bytes (master ACK, ACK, ACK, NACK) -> SDA returns 40 80 00 00. Without the macro: address NACKed.
- Assert reset for 1 clk after the 2nd data byte of a write -> SDA released; `busy` = 0; `result` = 0; a following full write 0x1A 3F 80 00 00 gives `result` = 32'h3F800000.
